// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester single-port memory arbiter (IDLE/ISSUE/RDATA)
// Optional round-robin tie-break with MEM_ARB_RR_EN; fixed priority to requester 0 otherwise.
module mem_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_wr_data,
  output logic             mem_write,
  input  logic [WIDTH-1:0] mem_rd_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;

  state_t           state_q, state_d;
  logic             winner_q, winner_d;
  logic             we_q, we_d;
  logic             last_winner_q, last_winner_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             pick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      winner_q      <= 1'b0;
      we_q          <= 1'b0;
      last_winner_q <= 1'b1;
      addr_q        <= '0;
      wdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      we_q          <= we_d;
      last_winner_q <= last_winner_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
    end
  end

  // pick is only meaningful when at least one request is high
  always_comb begin
`ifdef MEM_ARB_RR_EN
    pick = (req0 && req1) ? ~last_winner_q : ~req0;
`else
    pick = ~req0;
`endif
  end

  always_comb begin
    state_d       = state_q;
    winner_d      = winner_q;
    we_d          = we_q;
    last_winner_d = last_winner_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    rvalid0       = 1'b0;
    rvalid1       = 1'b0;
    mem_write     = 1'b0;
    rdata         = '0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          winner_d      = pick;
          last_winner_d = pick;
          we_d          = pick ? we1 : we0;
          addr_d        = pick ? addr1 : addr0;
          wdata_d       = pick ? wdata1 : wdata0;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        gnt0      = ~winner_q;
        gnt1      = winner_q;
        mem_write = we_q;
        state_d   = we_q ? IDLE : RDATA;
      end
      RDATA: begin
        rvalid0 = ~winner_q;
        rvalid1 = winner_q;
        rdata   = mem_rd_data;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_address = addr_q;
  assign mem_wr_data = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
// Expectations for tie-breaks follow MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_write;
  logic [31:0] rdata, mem_address, mem_wr_data, mem_rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_address(mem_address), .mem_wr_data(mem_wr_data),
    .mem_write(mem_write), .mem_rd_data(mem_rd_data)
  );

  typedef struct {
    logic        r0, r1, we0, we1;
    logic [31:0] a0, a1, d0, d1, mrd;
    logic        exp_win, exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("gnt_mutex", {31'b0, gnt0 & gnt1}, 32'd0);
    chk("rvalid_mutex", {31'b0, rvalid0 & rvalid1}, 32'd0);
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_gnt"}, {30'b0, gnt1, gnt0}, 32'd0);
    chk({tag, "_rvalid"}, {30'b0, rvalid1, rvalid0}, 32'd0);
    chk({tag, "_mem_write"}, {31'b0, mem_write}, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    req0 = v.r0; req1 = v.r1; we0 = v.we0; we1 = v.we1;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
    mem_rd_data = v.mrd;
    tick();
    chk({t, "_gnt0"}, {31'b0, gnt0}, {31'b0, ~v.exp_win});
    chk({t, "_gnt1"}, {31'b0, gnt1}, {31'b0, v.exp_win});
    chk({t, "_mem_write"}, {31'b0, mem_write}, {31'b0, v.exp_we});
    chk({t, "_mem_address"}, mem_address, v.exp_addr);
    chk({t, "_mem_wr_data"}, mem_wr_data, v.exp_wdata);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    if (!v.exp_we) begin
      chk({t, "_rvalid0"}, {31'b0, rvalid0}, {31'b0, ~v.exp_win});
      chk({t, "_rvalid1"}, {31'b0, rvalid1}, {31'b0, v.exp_win});
      chk({t, "_rdata"}, rdata, v.exp_rdata);
      chk({t, "_rd_mem_write"}, {31'b0, mem_write}, 32'd0);
      chk({t, "_rd_addr_hold"}, mem_address, v.exp_addr);
      tick();
    end
    idle_outputs({t, "_idle"});
    chk({t, "_idle_addr_hold"}, mem_address, v.exp_addr);
  endtask

  function automatic vec_t mk(input logic r0, r1, w0, w1,
                              input logic [31:0] a0, a1, d0, d1, mrd,
                              input logic win, ewe,
                              input logic [31:0] eaddr, ewd, erd);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.we0 = w0; v.we1 = w1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.mrd = mrd;
    v.exp_win = win; v.exp_we = ewe;
    v.exp_addr = eaddr; v.exp_wdata = ewd; v.exp_rdata = erd;
    return v;
  endfunction

  int grants[4];
  int exp_grants[4];
  int n_gnt;

  initial begin
    vecs[0] = mk(1, 0, 1, 0, 32'h0000FFFC, 32'h0, 32'hA5A5A5A5, 32'h0, 32'h55,
                 0, 1, 32'h0000FFFC, 32'hA5A5A5A5, 32'h0);
    vecs[1] = mk(0, 1, 0, 0, 32'h0, 32'h00000010, 32'h0, 32'hFFFFFFFF, 32'h12345678,
                 1, 0, 32'h00000010, 32'hFFFFFFFF, 32'h12345678);
    vecs[2] = mk(1, 0, 0, 0, 32'h00000100, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF,
                 0, 0, 32'h00000100, 32'h0, 32'hDEADBEEF);
    vecs[3] = mk(0, 1, 0, 1, 32'h0, 32'h00002000, 32'h0, 32'h0BADF00D, 32'h1,
                 1, 1, 32'h00002000, 32'h0BADF00D, 32'h0);
    vecs[4] = mk(1, 1, 1, 0, 32'h300, 32'h400, 32'h11111111, 32'h22222222, 32'h2,
                 0, 1, 32'h300, 32'h11111111, 32'h0);
`ifdef MEM_ARB_RR_EN
    vecs[5] = mk(1, 1, 1, 0, 32'h300, 32'h400, 32'h11111111, 32'h22222222, 32'hCAFEF00D,
                 1, 0, 32'h400, 32'h22222222, 32'hCAFEF00D);
    exp_grants = '{0, 1, 0, 1};
`else
    vecs[5] = mk(1, 1, 1, 0, 32'h300, 32'h400, 32'h11111111, 32'h22222222, 32'hCAFEF00D,
                 0, 1, 32'h300, 32'h11111111, 32'h0);
    exp_grants = '{0, 0, 0, 0};
`endif
    vecs[6] = mk(1, 1, 0, 1, 32'h500, 32'h504, 32'h0, 32'h33333333, 32'h0F0F0F0F,
                 0, 0, 32'h500, 32'h0, 32'h0F0F0F0F);
    vecs[7] = mk(0, 1, 0, 1, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h3,
                 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);

    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    mem_rd_data = 32'h9999_9999;
    tick();
    tick();
    idle_outputs("reset");
    chk("reset_mem_address", mem_address, 32'd0);
    chk("reset_mem_wr_data", mem_wr_data, 32'd0);
    rst = 1'b0;
    tick();
    idle_outputs("post_reset_idle");

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // requester 1 arrives while requester 0's read is in RDATA
    req0 = 1; we0 = 0; addr0 = 32'h700; mem_rd_data = 32'h89ABCDEF;
    tick();
    chk("late_gnt0", {31'b0, gnt0}, 32'd1);
    req0 = 0;
    tick();
    chk("late_rvalid0", {31'b0, rvalid0}, 32'd1);
    chk("late_rdata0", rdata, 32'h89ABCDEF);
    req1 = 1; we1 = 0; addr1 = 32'h800;
    tick();
    chk("late_no_gnt1_idle", {31'b0, gnt1}, 32'd0);
    tick();
    chk("late_gnt1", {31'b0, gnt1}, 32'd1);
    chk("late_addr1", mem_address, 32'h800);
    req1 = 0;
    tick();
    chk("late_rvalid1", {31'b0, rvalid1}, 32'd1);
    tick();
    idle_outputs("late_idle");

    // asynchronous reset in the middle of a read's ISSUE cycle
    req0 = 1; we0 = 0; addr0 = 32'h600; wdata0 = 32'h44; mem_rd_data = 32'h77;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    idle_outputs("abort_async");
    chk("abort_mem_address", mem_address, 32'd0);
    chk("abort_mem_wr_data", mem_wr_data, 32'd0);
    @(negedge clk);
    req0 = 0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      idle_outputs($sformatf("abort_quiet%0d", i));
    end
    run_vec(vecs[1], 101);

    // both requesters held for four reads starting from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0;
    addr0 = 32'hA0; addr1 = 32'hB0; mem_rd_data = 32'h5A5A;
    n_gnt = 0;
    for (int c = 0; c < 40 && n_gnt < 4; c++) begin
      tick();
      if (gnt0 || gnt1) begin
        grants[n_gnt] = gnt1 ? 1 : 0;
        n_gnt++;
      end
    end
    req0 = 0; req1 = 0;
    chk("tie_grant_count", n_gnt, 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < n_gnt) chk($sformatf("tie_grant%0d", i), grants[i], exp_grants[i]);
    tick();
    tick();
    idle_outputs("tie_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
